// File: rtl/bus_uart.sv
// bus_uart: bus-mapped 8N1 UART with programmable bit period, 8-entry RX FIFO,
// sticky error flags and a level interrupt.
//
// Ports
//   Clk            system clock, rising edge
//   ResetN         asynchronous active-low reset
//   Addr[2:0]      register word index
//   DataWr[15:0]   bus write data
//   DataRd[15:0]   read data, combinational from Addr and register state
//   En             chip select
//   Rd, Wr         bus strobes (levels)
//   Rx             asynchronous serial input
//   Tx             serial output, idle high
//   Int            level interrupt request
//
// Optional feature: define UART_LOOPBACK_EN to add CONTROL register 4 (b0 Loop),
// which routes the internal TX stream into the receiver and holds the Tx pin high.
module bus_uart (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [2:0]  Addr,
    input  logic [15:0] DataWr,
    output logic [15:0] DataRd,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        Rx,
    output logic        Tx,
    output logic        Int
);

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned FD = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = 3;

    localparam logic [DW-1:0] DIV_RST = 16'd433;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          wr_hist_q, wr_hist_d;
    logic          rd_hist_q, rd_hist_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] divisor_q, divisor_d;
    logic [1:0]    inten_q, inten_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [DW-1:0] tx_cnt_q, tx_cnt_d;
    logic [DW-1:0] tx_div_q, tx_div_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [BW-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0] tx_hold_q, tx_hold_d;
    logic          tx_hold_vld_q, tx_hold_vld_d;
    logic          tx_line_q, tx_line_d;

    logic          rx_s1_q, rx_s1_d;
    logic          rx_s2_q, rx_s2_d;
    logic          rx_prev_q, rx_prev_d;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [DW-1:0] rx_cnt_q, rx_cnt_d;
    logic [DW-1:0] rx_div_q, rx_div_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [BW-1:0] rx_shift_q, rx_shift_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] fifo_mem_q [FD];

`ifdef UART_LOOPBACK_EN
    logic          loop_q, loop_d;
    logic          tx_pin_q, tx_pin_d;
`endif

    logic          wr_commit, rd_act, rd_end, pop, push;
    logic          rx_avail, tx_ready, tx_idle;
    logic          rx_in, tx_tick;
    logic [DW:0]   rx_half_w;
    logic [DW-1:0] rx_half;
    logic [BW-1:0] fifo_head;

    // Bus strobe edge detection and status terms
    assign wr_commit = En & Wr & ~wr_hist_q;
    assign rd_act    = En & Rd;
    assign rd_end    = ~rd_act & rd_hist_q;
    assign rx_avail  = (count_q != 4'd0);
    assign tx_ready  = ~tx_hold_vld_q;
    assign tx_idle   = tx_ready & (tx_state_q == S_IDLE);
    assign pop       = rd_end & (rd_addr_q == 3'd0) & rx_avail;
    assign tx_tick   = (tx_cnt_q == tx_div_q);
    assign rx_half_w = {1'b0, rx_div_q} + 17'd1;
    assign rx_half   = rx_half_w[DW:1];
    assign fifo_head = fifo_mem_q[rd_ptr_q];

`ifdef UART_LOOPBACK_EN
    assign rx_in = loop_q ? tx_line_q : rx_s2_q;
    assign Tx    = tx_pin_q;
`else
    assign rx_in = rx_s2_q;
    assign Tx    = tx_line_q;
`endif

    // Next-state logic: bus registers, TX FSM, RX FSM, FIFO pointers
    always_comb begin
        wr_hist_d     = En & Wr;
        rd_hist_d     = rd_act;
        rd_addr_d     = rd_addr_q;
        divisor_d     = divisor_q;
        inten_d       = inten_q;
        overrun_d     = overrun_q;
        frame_err_d   = frame_err_q;
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_div_d      = tx_div_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_hold_d     = tx_hold_q;
        tx_hold_vld_d = tx_hold_vld_q;
        tx_line_d     = tx_line_q;
        rx_s1_d       = Rx;
        rx_s2_d       = rx_s1_q;
        rx_prev_d     = rx_in;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_div_d      = rx_div_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        push          = 1'b0;
`ifdef UART_LOOPBACK_EN
        loop_d        = loop_q;
        tx_pin_d      = tx_pin_q;
`endif

        // Remember the last address seen during a read strobe for the pop decision
        if (rd_act) begin
            rd_addr_d = Addr;
        end

        // Register writes (sticky-flag set below takes priority over clear)
        if (wr_commit) begin
            case (Addr)
                3'd0: begin
                    if (!tx_hold_vld_q) begin
                        tx_hold_d     = DataWr[7:0];
                        tx_hold_vld_d = 1'b1;
                    end
                end
                3'd1: begin
                    if (DataWr[3]) overrun_d = 1'b0;
                    if (DataWr[4]) frame_err_d = 1'b0;
                end
                3'd2: divisor_d = DataWr;
                3'd3: inten_d   = DataWr[1:0];
`ifdef UART_LOOPBACK_EN
                3'd4: loop_d    = DataWr[0];
`endif
                default: ;
            endcase
        end

        // Transmitter; bit period latched at every bit boundary
        case (tx_state_q)
            S_IDLE: begin
                if (tx_hold_vld_q) begin
                    tx_shift_d    = tx_hold_q;
                    tx_hold_vld_d = 1'b0;
                    tx_line_d     = 1'b0;
                    tx_cnt_d      = 16'd0;
                    tx_div_d      = divisor_q;
                    tx_state_d    = S_START;
                end
            end
            S_START: begin
                if (tx_tick) begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[BW-1:1]};
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = 16'd0;
                    tx_div_d   = divisor_q;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d = 16'd0;
                    tx_div_d = divisor_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[BW-1:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (tx_tick) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
        endcase

        // Receiver; counter starts at 1 on the detected falling edge so the
        // start sample lands floor((DIVISOR+1)/2) cycles into the bit
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_in) begin
                    rx_cnt_d   = 16'd1;
                    rx_div_d   = divisor_q;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q >= rx_half) begin
                    if (rx_in) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_cnt_d   = 16'd0;
                        rx_bit_d   = 3'd0;
                        rx_div_d   = divisor_q;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_shift_d = {rx_in, rx_shift_q[BW-1:1]};
                    rx_cnt_d   = 16'd0;
                    rx_div_d   = divisor_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = S_IDLE;
                    if (!rx_in) begin
                        frame_err_d = 1'b1;
                    end else if (count_q == 4'd8) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
        endcase

        // FIFO pointers
        if (push) wr_ptr_d = wr_ptr_q + 3'd1;
        if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
        count_d = count_q + CW'(push) - CW'(pop);

`ifdef UART_LOOPBACK_EN
        tx_pin_d = tx_line_d | loop_d;
`endif
    end

    // State registers
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_hist_q     <= 1'b0;
            rd_hist_q     <= 1'b0;
            rd_addr_q     <= 3'd0;
            divisor_q     <= DIV_RST;
            inten_q       <= 2'd0;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_state_q    <= S_IDLE;
            tx_cnt_q      <= 16'd0;
            tx_div_q      <= DIV_RST;
            tx_bit_q      <= 3'd0;
            tx_shift_q    <= 8'd0;
            tx_hold_q     <= 8'd0;
            tx_hold_vld_q <= 1'b0;
            tx_line_q     <= 1'b1;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= 16'd0;
            rx_div_q      <= DIV_RST;
            rx_bit_q      <= 3'd0;
            rx_shift_q    <= 8'd0;
            wr_ptr_q      <= 3'd0;
            rd_ptr_q      <= 3'd0;
            count_q       <= 4'd0;
`ifdef UART_LOOPBACK_EN
            loop_q        <= 1'b0;
            tx_pin_q      <= 1'b1;
`endif
        end else begin
            wr_hist_q     <= wr_hist_d;
            rd_hist_q     <= rd_hist_d;
            rd_addr_q     <= rd_addr_d;
            divisor_q     <= divisor_d;
            inten_q       <= inten_d;
            overrun_q     <= overrun_d;
            frame_err_q   <= frame_err_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_div_q      <= tx_div_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_hold_q     <= tx_hold_d;
            tx_hold_vld_q <= tx_hold_vld_d;
            tx_line_q     <= tx_line_d;
            rx_s1_q       <= rx_s1_d;
            rx_s2_q       <= rx_s2_d;
            rx_prev_q     <= rx_prev_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_div_q      <= rx_div_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
`ifdef UART_LOOPBACK_EN
            loop_q        <= loop_d;
            tx_pin_q      <= tx_pin_d;
`endif
        end
    end

    // FIFO storage; contents are only visible through count, so no reset needed
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    // Register read mux
    always_comb begin
        DataRd = 16'h0000;
        case (Addr)
            3'd0: DataRd = rx_avail ? {8'h00, fifo_head} : 16'h0000;
            3'd1: DataRd = {11'd0, frame_err_q, overrun_q, tx_ready, tx_idle, rx_avail};
            3'd2: DataRd = divisor_q;
            3'd3: DataRd = {14'd0, inten_q};
`ifdef UART_LOOPBACK_EN
            3'd4: DataRd = {15'd0, loop_q};
`endif
            default: DataRd = 16'h0000;
        endcase
    end

    assign Int = (inten_q[0] & rx_avail) | (inten_q[1] & tx_ready);

endmodule

// File: tb/tb_bus_uart.sv
// tb_bus_uart: directed, table-driven bench for bus_uart.
module tb_bus_uart;

    logic        Clk;
    logic        ResetN;
    logic [2:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        En;
    logic        Rd;
    logic        Wr;
    logic        Rx;
    logic        Tx;
    logic        Int;

    int checks;
    int errors;

    bus_uart dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .Addr   (Addr),
        .DataWr (DataWr),
        .DataRd (DataRd),
        .En     (En),
        .Rd     (Rd),
        .Wr     (Wr),
        .Rx     (Rx),
        .Tx     (Tx),
        .Int    (Int)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

`ifdef UART_LOOPBACK_EN
    localparam logic [15:0] LOOP_EXP = 16'h0001;
`else
    localparam logic [15:0] LOOP_EXP = 16'h0000;
`endif

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge Clk);
        Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
        repeat (2) @(negedge Clk);
        En = 1'b0; Wr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge Clk);
        Addr = a; En = 1'b1; Rd = 1'b1;
        repeat (2) @(negedge Clk);
        d = DataRd;
        En = 1'b0; Rd = 1'b0;
        @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        @(negedge Clk);
        Rx = 1'b0;
        repeat (per) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (per) @(negedge Clk);
        end
        Rx = stop_bit;
        repeat (per) @(negedge Clk);
        Rx = 1'b1;
    endtask

    initial begin
        logic [15:0] rd;
        logic        found;
        logic        s [40];
        logic [9:0]  fr;
        logic [3:0]  grp;
        logic        tx_bad;

        checks = 0;
        errors = 0;

        vecs[0]  = '{addr: 3'd2, wr: 1'b0, wdata: 16'h0000, exp_rd: 16'h01B1};
        vecs[1]  = '{addr: 3'd3, wr: 1'b0, wdata: 16'h0000, exp_rd: 16'h0000};
        vecs[2]  = '{addr: 3'd1, wr: 1'b0, wdata: 16'h0000, exp_rd: 16'h0006};
        vecs[3]  = '{addr: 3'd0, wr: 1'b0, wdata: 16'h0000, exp_rd: 16'h0000};
        vecs[4]  = '{addr: 3'd2, wr: 1'b1, wdata: 16'hBEEF, exp_rd: 16'hBEEF};
        vecs[5]  = '{addr: 3'd3, wr: 1'b1, wdata: 16'hFFFF, exp_rd: 16'h0003};
        vecs[6]  = '{addr: 3'd3, wr: 1'b1, wdata: 16'h0000, exp_rd: 16'h0000};
        vecs[7]  = '{addr: 3'd5, wr: 1'b1, wdata: 16'hFFFF, exp_rd: 16'h0000};
        vecs[8]  = '{addr: 3'd6, wr: 1'b1, wdata: 16'h1234, exp_rd: 16'h0000};
        vecs[9]  = '{addr: 3'd7, wr: 1'b0, wdata: 16'h0000, exp_rd: 16'h0000};
        vecs[10] = '{addr: 3'd1, wr: 1'b1, wdata: 16'hFFFF, exp_rd: 16'h0006};
        vecs[11] = '{addr: 3'd4, wr: 1'b1, wdata: 16'h0001, exp_rd: LOOP_EXP};
        vecs[12] = '{addr: 3'd4, wr: 1'b1, wdata: 16'h0000, exp_rd: 16'h0000};

        ResetN = 1'b0; Addr = 3'd0; DataWr = 16'h0000; En = 1'b0; Rd = 1'b0; Wr = 1'b0; Rx = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_tx", {15'd0, Tx}, 16'h0001);
        chk("reset_int", {15'd0, Int}, 16'h0000);
        ResetN = 1'b1;
        repeat (2) @(negedge Clk);

        // Register map
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            chk($sformatf("regmap_%0d", i), rd, vecs[i].exp_rd);
        end

        // Transmit 0xA5 with a 4-cycle bit period
        bus_write(3'd2, 16'd3);
        @(negedge Clk);
        Addr = 3'd0; DataWr = 16'h00A5; En = 1'b1; Wr = 1'b1;
        @(negedge Clk);
        Addr = 3'd1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (Tx === 1'b0) found = 1'b1;
            else @(negedge Clk);
        end
        chk("tx_start_seen", {15'd0, found}, 16'h0001);
        chk("txready_after_load", {14'd0, DataRd[2:1]}, 16'h0002);
        En = 1'b0; Wr = 1'b0;
        s[0] = Tx;
        for (int i = 1; i < 40; i++) begin
            @(negedge Clk);
            s[i] = Tx;
        end
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            grp = {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
            chk($sformatf("tx_bit_%0d", k), {12'd0, grp}, {12'd0, {4{fr[k]}}});
        end
        repeat (4) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("tx_idle_after_frame", rd, 16'h0006);

        // Receive one byte with a 10-cycle bit period
        bus_write(3'd2, 16'd9);
        send_frame(8'h3C, 1'b1, 10);
        repeat (5) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("rx_avail", rd, 16'h0007);
        bus_read(3'd0, rd);
        chk("rx_data_3c", rd, 16'h003C);
        bus_read(3'd1, rd);
        chk("rx_avail_cleared", rd, 16'h0006);

        // Nine frames without reads: eight stored, overrun flagged
        for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b1, 10);
        repeat (5) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("overrun_set", rd, 16'h000F);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'd0, rd);
            chk($sformatf("fifo_order_%0d", i), rd, 16'h0030 + 16'(i));
        end
        bus_read(3'd0, rd);
        chk("fifo_empty_read", rd, 16'h0000);
        bus_read(3'd1, rd);
        chk("overrun_sticky", rd, 16'h000E);
        bus_write(3'd1, 16'h0008);
        bus_read(3'd1, rd);
        chk("overrun_cleared", rd, 16'h0006);

        // Bad stop bit, then a short glitch
        send_frame(8'h55, 1'b0, 10);
        repeat (5) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("frame_err_set", rd, 16'h0016);
        bus_write(3'd1, 16'h0010);
        bus_read(3'd1, rd);
        chk("frame_err_cleared", rd, 16'h0006);
        @(negedge Clk);
        Rx = 1'b0;
        repeat (2) @(negedge Clk);
        Rx = 1'b1;
        repeat (30) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("glitch_ignored", rd, 16'h0006);

        // Interrupt sources
        bus_write(3'd3, 16'h0001);
        chk("int_rx_empty", {15'd0, Int}, 16'h0000);
        send_frame(8'h77, 1'b1, 10);
        repeat (5) @(negedge Clk);
        chk("int_rx_avail", {15'd0, Int}, 16'h0001);
        bus_read(3'd0, rd);
        chk("int_rx_data", rd, 16'h0077);
        chk("int_after_read", {15'd0, Int}, 16'h0000);
        bus_write(3'd3, 16'h0002);
        chk("int_tx_ready", {15'd0, Int}, 16'h0001);
        bus_write(3'd3, 16'h0000);

        // Asynchronous reset in the middle of TX and RX frames
        bus_write(3'd2, 16'd3);
        @(negedge Clk);
        Addr = 3'd0; DataWr = 16'h0000; En = 1'b1; Wr = 1'b1;
        @(negedge Clk);
        En = 1'b0; Wr = 1'b0; Rx = 1'b0;
        repeat (10) @(negedge Clk);
        chk("tx_low_midframe", {15'd0, Tx}, 16'h0000);
        #2;
        ResetN = 1'b0;
        #1;
        chk("tx_async_reset", {15'd0, Tx}, 16'h0001);
        Rx = 1'b1;
        repeat (2) @(negedge Clk);
        ResetN = 1'b1;
        repeat (50) @(negedge Clk);
        bus_read(3'd1, rd);
        chk("status_after_reset", rd, 16'h0006);
        bus_read(3'd2, rd);
        chk("divisor_after_reset", rd, 16'h01B1);

`ifdef UART_LOOPBACK_EN
        // Internal loopback keeps the pin idle
        bus_write(3'd2, 16'd3);
        bus_write(3'd4, 16'h0001);
        bus_write(3'd0, 16'h005A);
        tx_bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge Clk);
            if (Tx !== 1'b1) tx_bad = 1'b1;
        end
        chk("loop_tx_pin_high", {15'd0, tx_bad}, 16'h0000);
        bus_read(3'd1, rd);
        chk("loop_rx_avail", rd, 16'h0007);
        bus_read(3'd0, rd);
        chk("loop_rx_data", rd, 16'h005A);
        bus_write(3'd4, 16'h0000);
`else
        tx_bad = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_uart.md
BUS_UART -- requirements
Module: bus_uart

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 ResetN  input  1  reset, asynchronous assert, active-low.
REQ-003 Addr  input  3  register word index.
REQ-004 DataWr  input  16  write data from the bus interface.
REQ-005 DataRd  output  16  read data, combinational from Addr and register state.
REQ-006 En  input  1  chip-select decode for this block.
REQ-007 Rd / Wr  input  1 each  active-high bus strobes (levels, many Clk cycles long).
REQ-008 Rx  input  1  asynchronous serial in; Tx  output  1  serial out, idle high.
REQ-009 Int  output  1  level interrupt request, active high.

Function
REQ-010 Write commit on the first Clk where En&Wr=1 after a cycle where it was 0; exactly one commit per strobe.
REQ-011 Read side effects (FIFO pop) on the first Clk where En&Rd=0 after a cycle where it was 1.
REQ-012 Map: 0 DATA; 1 STATUS; 2 DIVISOR[15:0]; 3 INTEN[1:0]; 5-7 read 0, writes ignored.
REQ-013 DATA read: RX FIFO head in [7:0], [15:8]=0; FIFO empty -> 0x0000, no pop.
REQ-014 DATA write: [7:0] to TX holding register if free; if occupied, write dropped silently.
REQ-015 STATUS: b0 RxAvail, b1 TxIdle (holding empty and shifter idle), b2 TxReady (holding empty), b3 Overrun (sticky), b4 FrameErr (sticky); write 1 to b3/b4 clears them; other bits read 0.
REQ-016 Bit period = DIVISOR+1 Clk cycles; a DIVISOR write mid-frame takes effect at the next bit boundary.
REQ-017 Frame 8N1, LSB first.
REQ-018 TX FSM IDLE->START->DATA(8)->STOP->IDLE; holding register loads the shifter in IDLE, freeing holding the same cycle.
REQ-019 Rx passes through a 2-FF synchronizer before use.
REQ-020 RX FSM IDLE->START->DATA->STOP; start on synchronized 1->0; sample at mid-bit (floor((DIVISOR+1)/2) cycles in); start sample high -> abort to IDLE, no error.
REQ-021 Stop sample low -> FrameErr set, byte discarded.
REQ-022 Good byte, FIFO not full -> push; FIFO full -> byte discarded, Overrun set.
REQ-023 RX FIFO 8 entries, 3-bit pointers wrap modulo 8, 4-bit count.
REQ-024 Simultaneous push and pop -> count unchanged, both take effect.
REQ-025 Int = (INTEN[0]&RxAvail) | (INTEN[1]&TxReady), combinational from registers.

Reset
REQ-026 ResetN low asynchronously: Tx=1, both FSMs IDLE, FIFO empty, holding empty, STATUS sticky bits 0, DIVISOR=433, INTEN=0, Int=0, synchronizer FFs=1, strobe history=0.
REQ-027 ResetN low mid-frame aborts the frame immediately; no partial byte is pushed.

Configuration
REQ-028 UART_LOOPBACK_EN defined: register 4 CONTROL, b0 Loop (reset 0); Loop=1 -> receiver input = internal TX serial stream (synchronizer bypassed), Tx pin held 1.
REQ-029 UART_LOOPBACK_EN undefined: register 4 reads 0x0000, writes ignored, no loop path in logic.

Verification
REQ-030 DIVISOR=3, write DATA=0x00A5 -> Tx low 4 clk, bits 1,0,1,0,0,1,0,1 each 4 clk, high 4 clk; TxReady=1 the cycle after the shifter loads.
REQ-031 DIVISOR=9, drive 0x3C frame on Rx -> RxAvail=1; DATA read returns 0x003C; RxAvail=0 after strobe end.
REQ-032 9 frames, no reads -> 8 bytes stored in order, Overrun=1; write STATUS 0x0008 -> Overrun=0.
REQ-033 Frame with stop bit 0 -> FrameErr=1, RxAvail unchanged; 2-clk Rx low glitch -> no byte, no error.
REQ-034 INTEN=0x0001, receive one byte -> Int=1; read DATA -> Int=0; INTEN=0x0002 with holding empty -> Int=1.
REQ-035 With UART_LOOPBACK_EN, Loop=1, write 0x5A -> DATA reads 0x005A, Tx pin stays 1 throughout.
